// File: rtl/alu_result_stage_if.sv
// Handshake/data bundle for alu_result_stage: upstream ALU side (in_*) and writeback side (out_*).
// out_parity exists only when ALU_RESULT_PARITY_EN is defined.
interface alu_result_stage_if #(
    parameter int N  = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_result;
    logic [RW-1:0] in_dest;

    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_result;
    logic [RW-1:0] out_dest;
    logic          out_zero;
    logic          out_sign;
`ifdef ALU_RESULT_PARITY_EN
    logic          out_parity;
`endif
    logic [1:0]    occupancy;

    // master: the environment (ALU producer + writeback consumer)
    modport master (
        output in_valid, in_result, in_dest, out_ready,
        input  in_ready, out_valid, out_result, out_dest, out_zero, out_sign,
`ifdef ALU_RESULT_PARITY_EN
        input  out_parity,
`endif
        input  occupancy
    );

    // slave: the result stage itself
    modport slave (
        input  in_valid, in_result, in_dest, out_ready,
        output in_ready, out_valid, out_result, out_dest, out_zero, out_sign,
`ifdef ALU_RESULT_PARITY_EN
        output out_parity,
`endif
        output occupancy
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with a 2-entry skid buffer, capture-time zero/sign flags.
// Optional per-entry parity output enabled by defining ALU_RESULT_PARITY_EN.
//
// state | meaning
// EMPTY | no entry held, head regs keep last released values
// ONE   | head entry valid, skid empty
// FULL  | head and skid valid, in_ready low
module alu_result_stage #(
    parameter int N  = 32,
    parameter int RW = 5
) (
    input  logic clk,
    input  logic rst_n,
    alu_result_stage_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          in_ready_r;
    logic          accept, rel;
    logic          load_head_in, load_skid, move_skid;

    logic [N-1:0]  head_result, skid_result;
    logic [RW-1:0] head_dest, skid_dest;
    logic          head_zero, head_sign, skid_zero, skid_sign;
    logic          in_zero, in_sign;
`ifdef ALU_RESULT_PARITY_EN
    logic          head_parity, skid_parity, in_parity;
    assign in_parity = ^bus.in_result;
`endif

    assign in_zero = (bus.in_result == '0);
    assign in_sign = bus.in_result[N-1];

    always_comb begin
        state_nxt    = state;
        load_head_in = 1'b0;
        load_skid    = 1'b0;
        move_skid    = 1'b0;
        accept       = bus.in_valid & in_ready_r;
        rel          = (state != EMPTY) & bus.out_ready;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_head_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (accept && rel) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (rel) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (rel) begin
                    move_skid = 1'b1;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready_r  <= 1'b1;
            head_result <= '0;
            head_dest   <= '0;
            head_zero   <= 1'b0;
            head_sign   <= 1'b0;
            skid_result <= '0;
            skid_dest   <= '0;
            skid_zero   <= 1'b0;
            skid_sign   <= 1'b0;
`ifdef ALU_RESULT_PARITY_EN
            head_parity <= 1'b0;
            skid_parity <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            // registered ready: no combinational path from out_ready
            in_ready_r <= (state_nxt != FULL);
            if (load_head_in) begin
                head_result <= bus.in_result;
                head_dest   <= bus.in_dest;
                head_zero   <= in_zero;
                head_sign   <= in_sign;
`ifdef ALU_RESULT_PARITY_EN
                head_parity <= in_parity;
`endif
            end else if (move_skid) begin
                head_result <= skid_result;
                head_dest   <= skid_dest;
                head_zero   <= skid_zero;
                head_sign   <= skid_sign;
`ifdef ALU_RESULT_PARITY_EN
                head_parity <= skid_parity;
`endif
            end
            if (load_skid) begin
                skid_result <= bus.in_result;
                skid_dest   <= bus.in_dest;
                skid_zero   <= in_zero;
                skid_sign   <= in_sign;
`ifdef ALU_RESULT_PARITY_EN
                skid_parity <= in_parity;
`endif
            end
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = (state != EMPTY);
    assign bus.out_result = head_result;
    assign bus.out_dest   = head_dest;
    assign bus.out_zero   = head_zero;
    assign bus.out_sign   = head_sign;
`ifdef ALU_RESULT_PARITY_EN
    assign bus.out_parity = head_parity;
`endif
    assign bus.occupancy  = 2'(state);
endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized self-checking bench for alu_result_stage against a queue-based FIFO model.
// Build with ALU_RESULT_PARITY_EN defined to also check out_parity.
module tb_alu_result_stage;
    localparam int N  = 32;
    localparam int RW = 5;

    typedef struct {
        logic [N-1:0]  result;
        logic [RW-1:0] dest;
        bit            from_reset;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_result_stage_if #(.N(N), .RW(RW)) bus ();

    alu_result_stage #(.N(N), .RW(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     checks = 0;
    int     errors = 0;
    entry_t q[$];
    entry_t last;
    int     popped = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs: head of queue when non-empty, else the last value shown.
    task automatic check_outputs();
        entry_t e;
        e = (q.size() > 0) ? q[0] : last;
        check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        check("occupancy", 64'(bus.occupancy), 64'(q.size()));
        check("in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
        check("out_result", 64'(bus.out_result), 64'(e.result));
        check("out_dest",   64'(bus.out_dest),   64'(e.dest));
        check("out_zero", 64'(bus.out_zero), e.from_reset ? 64'd0 : 64'(e.result == 0));
        check("out_sign", 64'(bus.out_sign), e.from_reset ? 64'd0 : 64'(e.result[N-1]));
`ifdef ALU_RESULT_PARITY_EN
        check("out_parity", 64'(bus.out_parity), e.from_reset ? 64'd0 : 64'($countones(e.result) % 2));
`endif
    endtask

    // Called at a negedge: drive, check current outputs, advance one edge, update model.
    task automatic cycle(input logic iv, input logic [N-1:0] d, input logic [RW-1:0] rd,
                         input logic ordy, output bit acc);
        bit rel;
        bus.in_valid  = iv;
        bus.in_result = d;
        bus.in_dest   = rd;
        bus.out_ready = ordy;
        check_outputs();
        acc = iv && (q.size() < 2);
        rel = ordy && (q.size() > 0);
        @(posedge clk);
        if (rel) begin
            last = q.pop_front();
            popped++;
        end
        if (acc) q.push_back('{result: d, dest: rd, from_reset: 1'b0});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        q.delete();
        last = '{result: '0, dest: '0, from_reset: 1'b1};
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        bit acc;
        int cyc;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_dest   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        last = '{result: '0, dest: '0, from_reset: 1'b1};
        @(negedge clk);
        do_reset();

        // reset while FULL discards both entries
        cycle(1, 32'h0000_00FF, 5'd3, 0, acc);
        cycle(1, 32'h1234_5678, 5'd7, 0, acc);
        cycle(0, '0, '0, 0, acc);
        check("full_before_reset", 64'(bus.occupancy), 64'd2);
        do_reset();
        check("reset_out_result", 64'(bus.out_result), 64'd0);

        // single pass, sign flag
        cycle(1, 32'h8000_0000, 5'd5, 1, acc);
        check("single_sign", 64'(bus.out_sign), 64'd1);
        cycle(0, '0, '0, 1, acc);
        cycle(0, '0, '0, 1, acc);

        // zero flag and parity
        cycle(1, 32'h0000_0000, 5'd1, 1, acc);
        check("zero_flag", 64'(bus.out_zero), 64'd1);
        cycle(1, 32'h0000_0007, 5'd2, 1, acc);
        cycle(0, '0, '0, 1, acc);

        // back-pressure: 0xC held upstream until space opens
        cycle(1, 32'hA, 5'd10, 0, acc);
        cycle(1, 32'hB, 5'd11, 0, acc);
        cycle(1, 32'hC, 5'd12, 0, acc);
        check("bp_c_refused", 64'(acc), 64'd0);
        cycle(1, 32'hC, 5'd12, 0, acc);
        cyc = 0;
        acc = 0;
        while (!acc && cyc < 10) begin
            cycle(1, 32'hC, 5'd12, 1, acc);
            cyc++;
        end
        check("bp_c_accepted", 64'(acc), 64'd1);
        for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, acc);

        // streaming: one result per cycle, occupancy 1 in steady state
        popped = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1, 32'(i + 32'h100), 5'(i), 1, acc);
            if (i > 0) check("stream_occ", 64'(bus.occupancy), 64'd1);
        end
        check("stream_count", 64'(popped), 64'd99);
        cycle(0, '0, '0, 1, acc);

        // random valid/ready toggling
        popped = 0;
        cyc = 0;
        while (popped < 10000 && cyc < 60000) begin
            logic [N-1:0] d;
            d = $urandom();
            if ($urandom_range(0, 7) == 0) d = '0;
            cycle(logic'($urandom_range(0, 9) < 6), d, 5'($urandom()),
                  logic'($urandom_range(0, 9) < 6), acc);
            cyc++;
        end
        check("random_transfers", 64'(popped >= 10000), 64'd1);
        while (q.size() > 0 && cyc < 60010) begin
            cycle(0, '0, '0, 1, acc);
            cyc++;
        end
        check("drained", 64'(bus.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
